// File: rtl/arvi_muldiv_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the
// iterative RISC-V M-extension execute unit (ex_muldiv).
package arvi_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_signed_a(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_mul_high(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the shared 2*XLEN accumulator: shift-add for multiply,
// compare/subtract/shift (restoring) for divide. Purely combinational.
module ex_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          div_ge;

    always_comb begin
        // Multiply: {hi, multiplier}; add multiplicand into hi when lsb set, then shift right.
        mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
        // Divide: {remainder, dividend}; remainder < divisor keeps the borrow bit unambiguous.
        div_shift = acc_i[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_i};
        div_ge    = ~div_diff[XLEN];
        if (div_i) begin
            acc_o = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_i[XLEN-2:0], div_ge};
        end else begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative M-extension execute unit, one product/quotient bit per cycle.
// Build option ARVI_MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
//
//  state | meaning
//  IDLE  | ready for a request, o_res holds last result
//  BUSY  | iterating, counter counts XLEN down to 1
//  DONE  | result valid and held until i_ack
module ex_muldiv
    import arvi_muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic            o_valid,
    output logic [XLEN-1:0] o_res,
    input  logic            i_ack,
    output logic            o_stall
);

    muldiv_state_e     state_q;
    muldiv_op_e        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic              neg_q;
    logic              valid_q;
    logic [XLEN-1:0]   res_q;

    muldiv_op_e        req_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              req_neg;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        req_op   = muldiv_op_e'(i_f3);
        a_neg    = is_signed_a(req_op) & i_rs1[XLEN-1];
        b_neg    = is_signed_b(req_op) & i_rs2[XLEN-1];
        abs_a    = a_neg ? -i_rs1 : i_rs1;
        abs_b    = b_neg ? -i_rs2 : i_rs2;
        // Remainder takes the dividend's sign; product and quotient take the xor.
        req_neg  = is_rem(req_op) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(req_op) & (i_rs2 == '0);
        div_ovf  = (req_op == OP_DIV || req_op == OP_REM)
                   & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2);
        if (div_zero) begin
            special_res = is_rem(req_op) ? i_rs1 : '1;
        end else begin
            special_res = is_rem(req_op) ? '0 : i_rs1;
        end
    end

`ifdef ARVI_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a;
    logic [2*XLEN-1:0] fast_b;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        // Sign-extended operands give the exact low 2*XLEN bits of the product.
        fast_a    = {{XLEN{a_neg}}, i_rs1};
        fast_b    = {{XLEN{b_neg}}, i_rs2};
        fast_prod = fast_a * fast_b;
        fast_res  = is_mul_high(req_op) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
    end
`endif

    ex_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .div_i (is_div(op_q)),
        .acc_i (acc_q),
        .opb_i (opb_q),
        .acc_o (step_acc)
    );

    always_comb begin
        mul_fix = neg_q ? -step_acc : step_acc;
        div_sel = is_rem(op_q) ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
        if (is_div(op_q)) begin
            fin_res = neg_q ? -div_sel : div_sel;
        end else begin
            fin_res = is_mul_high(op_q) ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (i_kill) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_q  <= req_op;
                        neg_q <= req_neg;
                        acc_q <= {{XLEN{1'b0}}, abs_a};
                        opb_q <= abs_b;
                        cnt_q <= CNT_W'(XLEN);
                        if (div_zero || div_ovf) begin
                            res_q   <= special_res;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
`ifdef ARVI_MULDIV_FAST_MUL_EN
                        else if (!is_div(req_op)) begin
                            res_q   <= fast_res;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
`endif
                        else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        res_q   <= fin_res;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = valid_q;
    assign o_res   = res_q;
    // Combinational so the requesting instruction stalls in the same cycle it appears.
    assign o_stall = (state_q == BUSY) | (i_valid & (state_q != DONE))
                   | ((state_q == DONE) & ~i_ack);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (XLEN=32); honours ARVI_MULDIV_FAST_MUL_EN
// when computing expected multiply latency.
module tb_ex_muldiv;

    localparam int XLEN = 32;
    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_f3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic            i_kill;
    logic            o_valid;
    logic [XLEN-1:0] o_res;
    logic            i_ack;
    logic            o_stall;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_res;

    always #5 i_clk = ~i_clk;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_f3    (i_f3),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_kill  (i_kill),
        .o_valid (o_valid),
        .o_res   (o_res),
        .i_ack   (i_ack),
        .o_stall (o_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'd0, b});
        logic [63:0] p;
        logic [63:0] ua64 = {32'd0, a};
        logic [63:0] ub64 = {32'd0, b};
        case (f3)
            F_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            F_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            F_MULHU:  begin p = ua64 * ub64;  return p[63:32]; end
            F_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef ARVI_MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Called on a negedge with the unit idle; returns on the negedge after the accept edge.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv);
        i_valid = 1'b1;
        i_f3    = f3;
        i_rs1   = a;
        i_rs2   = b;
        exp_q.push_back(expv);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int lat_exp, input int hold, input bit do_ack);
        int lat = 1;
        bit stall_ok = 1'b1;
        bit hold_ok = 1'b1;
        logic [31:0] want;
        logic [31:0] got;
        while (!o_valid && lat < 100) begin
            if (!o_stall) stall_ok = 1'b0;
            @(negedge i_clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(lat_exp));
        if (lat > 1) check({tag, " stall busy"}, 64'(stall_ok), 64'd1);
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard: no expected entry", tag);
            n_checks++;
            want = 'x;
        end else begin
            want = exp_q.pop_front();
        end
        got = o_res;
        check({tag, " res"}, 64'(got), 64'(want));
        last_res = want;
        repeat (hold) begin
            @(negedge i_clk);
            if (o_res !== got || o_valid !== 1'b1) hold_ok = 1'b0;
        end
        if (hold > 0) check({tag, " hold"}, 64'(hold_ok), 64'd1);
        check({tag, " stall done"}, 64'(o_stall), 64'd1);
        if (do_ack) begin
            i_ack = 1'b1;
            #1;
            check({tag, " stall ack"}, 64'(o_stall), 64'd0);
            @(negedge i_clk);
            i_ack = 1'b0;
            check({tag, " valid after ack"}, 64'(o_valid), 64'd0);
            check({tag, " ready after ack"}, 64'(o_ready), 64'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv);
        send(f3, a, b, expv);
        collect(tag, exp_lat(f3, a, b), 0, 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bit seen_valid;
        logic [2:0] rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        i_rst = 1'b1; i_valid = 1'b0; i_kill = 1'b0; i_ack = 1'b0;
        i_f3 = '0; i_rs1 = '0; i_rs2 = '0; last_res = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        check("reset ready", 64'(o_ready), 64'd1);
        check("reset valid", 64'(o_valid), 64'd0);
        check("reset res",   64'(o_res),   64'd0);
        check("reset stall", 64'(o_stall), 64'd0);

        run_op("mul 7*-3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh min*min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu min*min", F_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu -1*ffff", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu ffff*ffff", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div -20/3", F_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_op("rem -20/3", F_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run_op("divu 20/3", F_DIVU, 32'd20, 32'd3, 32'd6);
        run_op("remu 20/3", F_REMU, 32'd20, 32'd3, 32'd2);
        run_op("divu 5/0", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem 5/0", F_REM, 32'd5, 32'd0, 32'd5);
        run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Kill on the 10th BUSY cycle.
        send(F_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        void'(exp_q.pop_back());
        repeat (9) @(negedge i_clk);
        i_kill = 1'b1;
        @(negedge i_clk);
        i_kill = 1'b0;
        check("kill ready", 64'(o_ready), 64'd1);
        check("kill res held", 64'(o_res), 64'(last_res));
        seen_valid = 1'b0;
        repeat (40) begin
            if (o_valid) seen_valid = 1'b1;
            @(negedge i_clk);
        end
        check("kill no valid", 64'(seen_valid), 64'd0);

        // Request presented together with kill is dropped.
        i_valid = 1'b1; i_kill = 1'b1; i_f3 = F_MUL; i_rs1 = 32'd3; i_rs2 = 32'd4;
        @(negedge i_clk);
        i_valid = 1'b0; i_kill = 1'b0;
        check("kill blocks accept", 64'(o_ready), 64'd1);

        // Reset mid-operation.
        send(F_DIVU, 32'd1000, 32'd7, 32'd142);
        void'(exp_q.pop_back());
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst res",   64'(o_res),   64'd0);
        check("midrst valid", 64'(o_valid), 64'd0);
        check("midrst ready", 64'(o_ready), 64'd1);
        run_op("mul 3*4", F_MUL, 32'd3, 32'd4, 32'd12);

        // Hold in DONE, then ack with a new request in the same cycle.
        send(F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        collect("hold mul", exp_lat(F_MUL, 32'd7, 32'hFFFF_FFFD), 5, 1'b0);
        i_ack = 1'b1; i_valid = 1'b1; i_f3 = F_DIVU; i_rs1 = 32'd20; i_rs2 = 32'd3;
        exp_q.push_back(32'd6);
        @(negedge i_clk);
        i_ack = 1'b0;
        check("ack+valid not accepted", 64'(o_ready), 64'd1);
        check("ack+valid valid low", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        collect("divu after ack", exp_lat(F_DIVU, 32'd20, 32'd3), 0, 1'b1);

        for (int k = 0; k < 16; k++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d f3=%0d", k, rf3), rf3, ra, rb, ref_res(rf3, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
